// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : ALU control codes shared by the ALU_Control decoder and EX stage.
//  Revision    : 1.0
// ============================================================================
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_ADD  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_ADDI = 3'b110,
        ALU_SRAI = 3'b111
    } alu_op_e;

    function automatic logic is_mul(input logic [2:0] code);
        return code == ALU_MUL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter_dp.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter_dp
//  Description : Shift-add multiply datapath; consumes STEP multiplier bits per step.
//  Revision    : 1.0
// ============================================================================
module mul_iter_dp #(
    parameter int DATA_W        = 32,
    parameter int MUL_STEP_BITS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] acc_o
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] slice_w;
    logic [DATA_W-1:0] pp_w;

    // Zero-extend the low multiplier slice so the product truncates to DATA_W.
    assign slice_w = {{(DATA_W-MUL_STEP_BITS){1'b0}}, b_q[MUL_STEP_BITS-1:0]};
    assign pp_w    = a_q * slice_w;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load_i) begin
            a_d   = a_i;
            b_d   = b_i;
            acc_d = '0;
        end else if (step_i) begin
            a_d   = a_q << MUL_STEP_BITS;
            b_d   = b_q >> MUL_STEP_BITS;
            acc_d = acc_q + pp_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_seq_ctrl
//  Description : EX-stage MUL sequencer: stalls the front end while mul_iter_dp runs.
//  Revision    : 1.0
// ============================================================================
module mul_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int MUL_STEP_BITS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic [2:0]        ALUCtrl_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    output logic              stall_o,
    output logic              mul_valid_o,
    output logic [DATA_W-1:0] mul_result_o
);

    localparam int ITER  = DATA_W / MUL_STEP_BITS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              mul_req_w;
    logic              load_w;
    logic              step_w;
    logic              show_acc_w;
    logic [DATA_W-1:0] acc_w;

    assign mul_req_w = ex_valid_i & is_mul(ALUCtrl_i) & ~flush_i;

    mul_iter_dp #(
        .DATA_W        (DATA_W),
        .MUL_STEP_BITS (MUL_STEP_BITS)
    ) u_dp (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (load_w),
        .step_i (step_w),
        .a_i    (rs1_data_i),
        .b_i    (rs2_data_i),
        .acc_o  (acc_w)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        load_w      = 1'b0;
        step_w      = 1'b0;
        show_acc_w  = 1'b0;
        stall_o     = 1'b0;
        mul_valid_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = mul_req_w;
                if (mul_req_w) begin
                    load_w  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    stall_o = 1'b1;
                    step_w  = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The finished accumulator drives the output directly this cycle;
                // a flush here leaves the previously held result visible.
                state_d = ST_IDLE;
                if (!flush_i) begin
                    mul_valid_o = 1'b1;
                    show_acc_w  = 1'b1;
                    result_d    = acc_w;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mul_result_o = show_acc_w ? acc_w : result_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_seq_ctrl
//  Description : Scoreboard bench for mul_seq_ctrl with a plain-arithmetic reference.
//  Revision    : 1.0
// ============================================================================
module tb_mul_seq_ctrl;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int STEP   = 8;
    localparam int ITER   = DATA_W / STEP;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic [2:0]        alu_ctrl;
    logic              flush;
    logic [DATA_W-1:0] rs1;
    logic [DATA_W-1:0] rs2;
    logic              stall;
    logic              mul_valid;
    logic [DATA_W-1:0] mul_result;

    always #5 clk = ~clk;

    mul_seq_ctrl #(
        .DATA_W        (DATA_W),
        .MUL_STEP_BITS (STEP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .ex_valid_i   (ex_valid),
        .ALUCtrl_i    (alu_ctrl),
        .flush_i      (flush),
        .rs1_data_i   (rs1),
        .rs2_data_i   (rs2),
        .stall_o      (stall),
        .mul_valid_o  (mul_valid),
        .mul_result_o (mul_result)
    );

    typedef struct {
        logic [DATA_W-1:0] prod;
        int unsigned       due;
    } exp_t;

    exp_t              sb[$];
    int unsigned       cyc = 0;
    int                passed = 0;
    int                total = 0;
    logic [DATA_W-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every pulse must match the oldest outstanding product and its due cycle.
    always @(negedge clk) begin
        if (mul_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'(mul_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mul_result", mul_result, e.prod);
                check("mul_latency", cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_stall(input string name, input logic exp);
        @(negedge clk);
        check(name, 32'(stall), 32'(exp));
    endtask

    function automatic logic [DATA_W-1:0] pick_operand();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            2:       return 32'd1 << ($urandom % 32);
            default: return $urandom;
        endcase
    endfunction

    // Called at the start of a cycle; returns at the start of the cycle after DONE.
    task automatic do_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_t e;
        e.prod   = a * b;
        e.due    = cyc + ITER + 1;
        ex_valid = 1'b1;
        alu_ctrl = ALU_MUL;
        flush    = 1'b0;
        rs1      = a;
        rs2      = b;
        sb.push_back(e);
        sample_stall("stall_issue", 1'b1);
        for (int k = 0; k < ITER; k++) begin
            tick();
            rs1 = $urandom;
            rs2 = $urandom;
            sample_stall("stall_run", 1'b1);
        end
        tick();
        sample_stall("stall_done", 1'b0);
        last_res = e.prod;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            logic [2:0] op;
            rs1 = $urandom;
            rs2 = $urandom;
            case ($urandom % 3)
                0: begin
                    op = 3'($urandom_range(0, 7));
                    if (op == ALU_MUL) op = ALU_ADD;
                    ex_valid = 1'b1; alu_ctrl = op; flush = 1'b0;
                end
                1: begin ex_valid = 1'b0; alu_ctrl = ALU_MUL; flush = 1'b0; end
                default: begin ex_valid = 1'b1; alu_ctrl = ALU_MUL; flush = 1'b1; end
            endcase
            sample_stall("stall_nonmul", 1'b0);
            check("result_hold", mul_result, last_res);
            tick();
        end
        ex_valid = 1'b0;
        flush    = 1'b0;
    endtask

    // Start a MUL and kill it in its second RUN cycle by flush or by reset.
    task automatic abort_mul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                             input logic use_rst);
        ex_valid = 1'b1;
        alu_ctrl = ALU_MUL;
        flush    = 1'b0;
        rs1      = a;
        rs2      = b;
        sample_stall("abort_issue", 1'b1);
        tick();
        tick();
        if (use_rst) begin
            rst_n = 1'b0;
            tick();
            rst_n    = 1'b1;
            ex_valid = 1'b0;
            last_res = '0;
            @(negedge clk);
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_valid", 32'(mul_valid), 32'd0);
            check("rst_result", mul_result, 32'd0);
        end else begin
            flush = 1'b1;
            sample_stall("flush_stall", 1'b0);
            tick();
            flush    = 1'b0;
            ex_valid = 1'b0;
            @(negedge clk);
            check("flush_stall_after", 32'(stall), 32'd0);
            check("flush_result", mul_result, last_res);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        alu_ctrl = ALU_ADD;
        flush    = 1'b0;
        rs1      = '0;
        rs2      = '0;
        repeat (3) tick();
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_valid", 32'(mul_valid), 32'd0);
        check("reset_result", mul_result, 32'd0);
        tick();
        rst_n = 1'b1;

        do_mul(32'd7, 32'd6);
        idle_cycles(2);
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_mul(32'h8000_0000, 32'd2);
        idle_cycles(12);
        do_mul(32'd3, 32'd5);
        do_mul(32'h0001_0000, 32'h0001_0000);
        idle_cycles(2);
        do_mul(32'd11, 32'd13);
        abort_mul(32'd100, 32'd200, 1'b0);
        idle_cycles(3);
        abort_mul(32'd100, 32'd200, 1'b1);
        idle_cycles(1);
        do_mul(32'd9, 32'd9);

        for (int i = 0; i < 30; i++) begin
            if ($urandom % 2) do_mul(pick_operand(), pick_operand());
            else idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
